vga_dither_out: RTL and testbench

VGA_DITHER_OUT -- requirements
Module: vga_dither_out

---
 rtl/vga_dither_out.sv | 150 +++++++++++++++
 tb/tb_vga_dither_out.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/vga_dither_out.sv
// Ordered-dither output stage: reduces 24-bit RGB to 1 bit per channel for the TFP410.
// Two registered stages: stage 1 samples video and matrix indices, stage 2 thresholds and drives pins.

module vga_dither_lane #(
    parameter int VEC_W = 8
) (
    input  logic [VEC_W-1:0] ch_i,
    input  logic [VEC_W:0]   thr_i,
    input  logic             dither_en_i,
    output logic             bit_o
);
    // Widen by one bit so the threshold compare is unsigned and cannot wrap.
    assign bit_o = dither_en_i ? ({1'b0, ch_i} >= thr_i) : ch_i[VEC_W-1];
endmodule

module vga_dither_out #(
    parameter logic VS_POL   = 1'b1,
    parameter logic TEMPORAL = 1'b0
) (
    input  logic        clk_40m,
    input  logic        reset_loc,
    input  logic        vga_de,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [23:0] vga_rgb,
    input  logic        dither_en,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_r,
    output logic        out_g,
    output logic        out_b,
    output logic [1:0]  frame_cnt
);
    localparam int NUM_LANES = 3;
    localparam int VEC_W     = 8;
    localparam int STAGES    = 2;

    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] b;
        case ({row, col})
            4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
            4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
            4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
            4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  default: b = 4'd5;
        endcase
        return b;
    endfunction

    // Position counters and edge detection
    logic [1:0] cx_q, cx_d;
    logic [1:0] cy_q, cy_d;
    logic [1:0] fc_q, fc_d;
    logic       vs_act_q;
    logic       vs_act, vs_lead, de_fall;
    logic [1:0] f, row_base, col_idx, row_idx;

    // Pipeline registers
    logic [STAGES:1]                    vld_pipe_q;
    logic [STAGES:1]                    hs_pipe_q;
    logic [STAGES:1]                    vs_pipe_q;
    logic [NUM_LANES-1:0][VEC_W-1:0]    rgb_s1_q;
    logic                               den_s1_q;
    logic [1:0]                         col_s1_q, row_s1_q;
    logic [NUM_LANES-1:0]               pix_s2_q, pix_d;
    logic [1:0]                         frame_cnt_q;
    logic [VEC_W:0]                     thr;

    assign vs_act  = (vga_vs == VS_POL);
    assign vs_lead = vs_act & ~vs_act_q;
    assign de_fall = vld_pipe_q[1] & ~vga_de;

    always_comb begin
        cx_d = vga_de ? cx_q + 2'd1 : 2'd0;
        cy_d = cy_q;
        if (vs_lead)
            cy_d = 2'd0;
        else if (de_fall)
            cy_d = cy_q + 2'd1;
        fc_d = fc_q + {1'b0, vs_lead};
    end

    // The frame count used here is the one this pixel carries at the output,
    // so a pixel coinciding with the vs edge already sees the new frame.
    assign f        = TEMPORAL ? fc_d : 2'd0;
    assign row_base = vs_lead ? 2'd0 : cy_q;
    assign col_idx  = cx_q + f;
    assign row_idx  = row_base + f;

    always_ff @(posedge clk_40m or posedge reset_loc) begin
        if (reset_loc) begin
            cx_q       <= '0;
            cy_q       <= '0;
            fc_q       <= '0;
            vs_act_q   <= 1'b0;
            vld_pipe_q <= '0;
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
            rgb_s1_q   <= '0;
            den_s1_q   <= 1'b0;
            col_s1_q   <= '0;
            row_s1_q   <= '0;
        end else begin
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            fc_q       <= fc_d;
            vs_act_q   <= vs_act;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], vga_de};
            hs_pipe_q  <= {hs_pipe_q[STAGES-1:1], vga_hs};
            vs_pipe_q  <= {vs_pipe_q[STAGES-1:1], vga_vs};
            rgb_s1_q   <= vga_rgb;
            den_s1_q   <= dither_en;
            col_s1_q   <= col_idx;
            row_s1_q   <= row_idx;
        end
    end

    // Threshold 16*B + 8, shared by all channels.
    assign thr = {1'b0, bayer(row_s1_q, col_s1_q), 4'b1000};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            vga_dither_lane #(.VEC_W(VEC_W)) u_lane (
                .ch_i        (rgb_s1_q[gi]),
                .thr_i       (thr),
                .dither_en_i (den_s1_q),
                .bit_o       (pix_d[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_40m or posedge reset_loc) begin
        if (reset_loc) begin
            pix_s2_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            pix_s2_q    <= vld_pipe_q[1] ? pix_d : '0;
            frame_cnt_q <= fc_q;
        end
    end

    assign out_de    = vld_pipe_q[STAGES];
    assign out_hs    = hs_pipe_q[STAGES];
    assign out_vs    = vs_pipe_q[STAGES];
    assign out_r     = pix_s2_q[2];
    assign out_g     = pix_s2_q[1];
    assign out_b     = pix_s2_q[0];
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_vga_dither_out.sv
// Directed bench for vga_dither_out: one static-matrix and one temporal instance
// driven by the same video stream, each output compared one call after its pixel.

module tb_vga_dither_out;
    logic        clk_40m = 1'b0;
    logic        reset_loc = 1'b0;
    logic        vga_de = 1'b0, vga_hs = 1'b0, vga_vs = 1'b0;
    logic [23:0] vga_rgb = '0;
    logic        dither_en = 1'b0;

    logic       de0, hs0, vs0, r0, g0, b0;
    logic       de1, hs1, vs1, r1, g1, b1;
    logic [1:0] fc0, fc1;

    vga_dither_out #(.VS_POL(1'b1), .TEMPORAL(1'b0)) u_dut (
        .clk_40m(clk_40m), .reset_loc(reset_loc), .vga_de(vga_de), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_rgb(vga_rgb), .dither_en(dither_en),
        .out_de(de0), .out_hs(hs0), .out_vs(vs0), .out_r(r0), .out_g(g0), .out_b(b0),
        .frame_cnt(fc0)
    );

    vga_dither_out #(.VS_POL(1'b1), .TEMPORAL(1'b1)) u_dut_t (
        .clk_40m(clk_40m), .reset_loc(reset_loc), .vga_de(vga_de), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_rgb(vga_rgb), .dither_en(dither_en),
        .out_de(de1), .out_hs(hs1), .out_vs(vs1), .out_r(r1), .out_g(g1), .out_b(b1),
        .frame_cnt(fc1)
    );

    always #5 clk_40m = ~clk_40m;

    typedef struct packed {
        logic       v, de, hs, vs;
        logic [2:0] c0, c1;
        logic [1:0] fc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t pend = '0;
    int   bay[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    function automatic logic px(input logic [7:0] ch, input logic den, input int b);
        if (den) return (int'(ch) >= 16 * b + 8);
        return ch[7];
    endfunction

    function automatic logic [2:0] exp_rgb(input logic de, input logic den, input logic [23:0] rgb,
                                           input int row, input int col);
        int b;
        if (!de) return 3'b000;
        b = bay[row % 4][col % 4];
        return {px(rgb[23:16], den, b), px(rgb[15:8], den, b), px(rgb[7:0], den, b)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pend();
        chk("de",     {7'd0, de0}, {7'd0, pend.de});
        chk("hs",     {7'd0, hs0}, {7'd0, pend.hs});
        chk("vs",     {7'd0, vs0}, {7'd0, pend.vs});
        chk("rgb",    {5'd0, r0, g0, b0}, {5'd0, pend.c0});
        chk("fc",     {6'd0, fc0}, {6'd0, pend.fc});
        chk("de_t",   {7'd0, de1}, {7'd0, pend.de});
        chk("rgb_t",  {5'd0, r1, g1, b1}, {5'd0, pend.c1});
        chk("fc_t",   {6'd0, fc1}, {6'd0, pend.fc});
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {1'b0, de0, hs0, vs0, r0, g0, b0, 1'b0}, 8'h00);
        chk(tag, {1'b0, de1, hs1, vs1, r1, g1, b1, 1'b0}, 8'h00);
        chk(tag, {4'd0, fc0, fc1}, 8'h00);
    endtask

    // Apply one pixel; row/col are the untranslated tile coordinates, f the frame it belongs to.
    task automatic cyc(input logic de, input logic vs, input logic [23:0] rgb, input logic den,
                       input int row, input int col, input int f);
        exp_t e;
        vga_de = de; vga_hs = !de; vga_vs = vs; vga_rgb = rgb; dither_en = den;
        e.v  = 1'b1;
        e.de = de;
        e.hs = !de;
        e.vs = vs;
        e.c0 = exp_rgb(de, den, rgb, row, col);
        e.c1 = exp_rgb(de, den, rgb, row + f, col + f);
        e.fc = f[1:0];
        @(posedge clk_40m); #1;
        if (pend.v) check_pend();
        pend = e;
    endtask

    task automatic blank(input logic vs, input int f);
        cyc(1'b0, vs, 24'hFFFFFF, 1'b1, 0, 0, f);
    endtask

    initial begin
        #1 reset_loc = 1'b1;
        #2 check_zero("reset");
        @(posedge clk_40m); @(posedge clk_40m); #1;
        check_zero("reset_clk");
        reset_loc = 1'b0;

        blank(1'b0, 0);
        blank(1'b1, 1);
        blank(1'b0, 1);
        // Truncation line, 6 pixels
        for (int c = 0; c < 6; c++) cyc(1'b1, 1'b0, 24'h807FFF, 1'b0, 0, c, 1);
        blank(1'b0, 1);
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 24'h080808, 1'b1, 1, c, 1);
        blank(1'b0, 1);
        // New frame: 4x4 block starting at row 0
        blank(1'b1, 2);
        blank(1'b0, 2);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++)
                cyc(1'b1, 1'b0, (r < 2) ? 24'h8008FF : 24'h808000, 1'b1, r, c, 2);
            blank(1'b0, 2);
        end
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 24'h7F0900, 1'b1, 0, c, 2);
        blank(1'b0, 2);
        // vs leading edge coincident with an active pixel
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 24'h080808, 1'b1, 0, c, 3);
        blank(1'b0, 3);
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 24'h080808, 1'b1, 1, c, 3);
        // de falling edge and vs edge together: the clear wins, frame wraps 3->0
        blank(1'b1, 0);
        blank(1'b0, 0);
        for (int c = 0; c < 6; c++) cyc(1'b1, 1'b0, 24'h0808F0, 1'b1, 0, c, 0);
        cyc(1'b1, 1'b0, 24'hFFFFFF, 1'b1, 0, 6, 0);
        cyc(1'b1, 1'b0, 24'hFFFFFF, 1'b1, 0, 7, 0);
        // Asynchronous reset mid-line
        #2 reset_loc = 1'b1;
        #1 check_zero("async_rst");
        pend = '0;
        @(posedge clk_40m); #1;
        check_zero("rst_hold");
        reset_loc = 1'b0;
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 24'h080808, 1'b1, 0, c, 1);
        blank(1'b0, 1);
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 24'h080808, 1'b1, 1, c, 1);
        blank(1'b0, 1);
        blank(1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
